br_resolve_unit: RTL and testbench

Parametrised successor to the single-bit branch-equal select used in the RISC CPU execute path. The block resolves conditional branches over full-width operands with six compare modes plus an unconditional mode, and computes the next PC. It keeps a 2-bit branch history table (BHT) that fetch reads, and flags and counts mispredictions. One registered stage sits between the decode/execute operand latch and the PC update and flush logic.

---
 rtl/br_resolve_unit.sv | 129 ++++++++++++
 tb/tb_br_resolve_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_unit.sv
// Branch resolve stage: one registered stage from the operand latch to the PC
// update, with a 2-bit branch history table read by fetch and a mispredict counter.
module br_resolve_unit #(
  parameter int WIDTH     = 16,
  parameter int PC_W      = 16,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic [2:0]       Cond,
  input  logic [PC_W-1:0]  PC,
  input  logic [PC_W-1:0]  Offset,
  input  logic             PredTaken,
  input  logic             Flush,
  input  logic [PC_W-1:0]  LookupPC,
  output logic             LookupTaken,
  output logic             OutValid,
  output logic             Taken,
  output logic [PC_W-1:0]  NextPC,
  output logic             Mispredict,
  output logic             IllegalCond,
  output logic [CNT_W-1:0] MispCount
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic             valid_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       cond_reg;
  logic [PC_W-1:0]  pc_reg;
  logic [PC_W-1:0]  off_reg;
  logic             pred_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       bht_reg [BHT_DEPTH];

  logic             cond_true;
  logic             taken;
  logic             misp;
  logic             bht_upd;
  logic [IDX_W-1:0] bht_idx;
  logic [IDX_W-1:0] look_idx;
  logic             lookup_unused;

  // Flush only clears the valid bit; the payload is don't-care while invalid.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      cond_reg  <= '0;
      pc_reg    <= '0;
      off_reg   <= '0;
      pred_reg  <= 1'b0;
    end else if (Flush) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= InValid;
      a_reg     <= InA;
      b_reg     <= InB;
      cond_reg  <= Cond;
      pc_reg    <= PC;
      off_reg   <= Offset;
      pred_reg  <= PredTaken;
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond_reg)
      3'b000:  cond_true = (a_reg == b_reg);
      3'b001:  cond_true = (a_reg != b_reg);
      3'b100:  cond_true = ($signed(a_reg) < $signed(b_reg));
      3'b101:  cond_true = !($signed(a_reg) < $signed(b_reg));
      3'b110:  cond_true = (a_reg < b_reg);
      3'b111:  cond_true = !(a_reg < b_reg);
      3'b010:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign taken = valid_reg & cond_true;
  assign misp  = valid_reg & (taken != pred_reg);

  assign OutValid    = valid_reg;
  assign Taken       = taken;
  assign Mispredict  = misp;
  assign IllegalCond = valid_reg & (cond_reg == 3'b011);
  assign NextPC      = !valid_reg ? '0 :
                       taken      ? pc_reg + off_reg : pc_reg + PC_W'(1);
  assign MispCount   = cnt_reg;

  // ALWAYS (010) and reserved (011) share cond[2:1]==01 and never train the table.
  assign bht_upd  = valid_reg & (cond_reg[2:1] != 2'b01);
  assign bht_idx  = pc_reg[IDX_W-1:0];
  assign look_idx = LookupPC[IDX_W-1:0];

  assign LookupTaken   = bht_reg[look_idx][1];
  assign lookup_unused = ^LookupPC;

  generate
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      always_ff @(posedge Clk) begin
        if (Rst) begin
          bht_reg[gi] <= 2'b01;
        end else if (bht_upd && (bht_idx == IDX_W'(gi))) begin
          if (taken) begin
            if (bht_reg[gi] != 2'b11) bht_reg[gi] <= bht_reg[gi] + 2'b01;
          end else begin
            if (bht_reg[gi] != 2'b00) bht_reg[gi] <= bht_reg[gi] - 2'b01;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_reg <= '0;
    end else if (misp && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_br_resolve_unit.sv
// Scoreboard bench for br_resolve_unit: directed branches push expected results,
// a monitor pops them whenever OutValid is seen.
module tb_br_resolve_unit;

  typedef struct packed {
    logic        taken;
    logic [15:0] npc;
    logic        misp;
    logic        ill;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        InValid = 1'b0;
  logic [15:0] InA = '0;
  logic [15:0] InB = '0;
  logic [2:0]  Cond = '0;
  logic [15:0] PC = '0;
  logic [15:0] Offset = '0;
  logic        PredTaken = 1'b0;
  logic        Flush = 1'b0;
  logic [15:0] LookupPC = '0;
  logic        LookupTaken, OutValid, Taken, Mispredict, IllegalCond;
  logic [15:0] NextPC, MispCount;
  logic        LookupTaken_s, OutValid_s, Taken_s, Mispredict_s, IllegalCond_s;
  logic [15:0] NextPC_s;
  logic [1:0]  MispCount_s;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 Clk = ~Clk;

  br_resolve_unit #(.WIDTH(16), .PC_W(16), .BHT_DEPTH(16), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InA(InA), .InB(InB), .Cond(Cond),
    .PC(PC), .Offset(Offset), .PredTaken(PredTaken), .Flush(Flush), .LookupPC(LookupPC),
    .LookupTaken(LookupTaken), .OutValid(OutValid), .Taken(Taken), .NextPC(NextPC),
    .Mispredict(Mispredict), .IllegalCond(IllegalCond), .MispCount(MispCount)
  );

  // Narrow-counter copy sharing all inputs, to exercise counter saturation.
  br_resolve_unit #(.WIDTH(16), .PC_W(16), .BHT_DEPTH(16), .CNT_W(2)) dut_s (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InA(InA), .InB(InB), .Cond(Cond),
    .PC(PC), .Offset(Offset), .PredTaken(PredTaken), .Flush(Flush), .LookupPC(LookupPC),
    .LookupTaken(LookupTaken_s), .OutValid(OutValid_s), .Taken(Taken_s), .NextPC(NextPC_s),
    .Mispredict(Mispredict_s), .IllegalCond(IllegalCond_s), .MispCount(MispCount_s)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end else begin
      $display("ok   %s: %h at %0t", name, got, $time);
    end
  endtask

  task automatic idle();
    @(posedge Clk); #1;
    InValid = 1'b0;
    Flush   = 1'b0;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                       input logic [15:0] pc, input logic [15:0] off, input logic pred,
                       input logic fl);
    @(posedge Clk); #1;
    InValid = 1'b1; InA = a; InB = b; Cond = c; PC = pc; Offset = off;
    PredTaken = pred; Flush = fl;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                       input logic [15:0] pc, input logic [15:0] off, input logic pred,
                       input logic et, input logic [15:0] enpc, input logic em,
                       input logic ei);
    exp_t e;
    drive(a, b, c, pc, off, pred, 1'b0);
    e.taken = et; e.npc = enpc; e.misp = em; e.ill = ei;
    sb_q.push_back(e);
  endtask

  task automatic look(input logic [15:0] addr, input logic exp);
    LookupPC = addr;
    #1;
    chk($sformatf("lookup[%h]", addr), {31'b0, LookupTaken}, {31'b0, exp});
  endtask

  // Monitor: compares result fields and tracks the expected mispredict count.
  initial begin : monitor
    exp_t        e;
    logic        got_misp;
    logic [15:0] exp_cnt;
    exp_cnt = '0;
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      got_misp = 1'b0;
      if (OutValid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_outvalid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("taken", {31'b0, Taken}, {31'b0, e.taken});
          chk("nextpc", {16'b0, NextPC}, {16'b0, e.npc});
          chk("mispredict", {31'b0, Mispredict}, {31'b0, e.misp});
          chk("illegal", {31'b0, IllegalCond}, {31'b0, e.ill});
          got_misp = e.misp;
        end
      end else begin
        chk("idle_flags", {29'b0, Taken, Mispredict, IllegalCond}, 32'd0);
      end
      chk("mispcount", {16'b0, MispCount}, {16'b0, exp_cnt});
      chk("mispcount_w2", {30'b0, MispCount_s},
          (exp_cnt > 16'd3) ? 32'd3 : {16'b0, exp_cnt});
      if (Rst) exp_cnt = '0;
      else if (got_misp && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
  end

  initial begin : stimulus
    int wait_cyc;
    @(posedge Clk); #1;
    chk("reset_outvalid", {31'b0, OutValid}, 32'd0);
    chk("reset_nextpc", {16'b0, NextPC}, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    for (int i = 0; i < 16; i++) look(16'(i), 1'b0);

    // Signed vs unsigned compares on 0xFFFF vs 0x0001, back to back.
    issue(16'hFFFF, 16'h0001, 3'b100, 16'h0010, 16'h0008, 1'b0, 1'b1, 16'h0018, 1'b1, 1'b0);
    issue(16'hFFFF, 16'h0001, 3'b110, 16'h0010, 16'h0008, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0001, 3'b000, 16'h0010, 16'h0008, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0001, 3'b001, 16'h0010, 16'h0008, 1'b0, 1'b1, 16'h0018, 1'b1, 1'b0);
    issue(16'hFFFF, 16'h0001, 3'b101, 16'h0010, 16'h0008, 1'b1, 1'b0, 16'h0011, 1'b1, 1'b0);
    issue(16'hFFFF, 16'h0001, 3'b111, 16'h0010, 16'h0008, 1'b1, 1'b1, 16'h0018, 1'b0, 1'b0);
    idle();

    // Target wrap-around and ALWAYS not training the table.
    issue(16'h0000, 16'h0000, 3'b010, 16'hFFFE, 16'h0004, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0);
    issue(16'h0001, 16'h0002, 3'b000, 16'hFFFE, 16'h0004, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    issue(16'h0000, 16'h0000, 3'b010, 16'h001A, 16'h0004, 1'b0, 1'b1, 16'h001E, 1'b1, 1'b0);
    idle(); idle();
    look(16'h000A, 1'b0);

    // Counter at index 3 saturating at 11, then decaying.
    look(16'h0003, 1'b0);
    issue(16'h0005, 16'h0005, 3'b000, 16'h0013, 16'h0010, 1'b0, 1'b1, 16'h0023, 1'b1, 1'b0);
    issue(16'h0005, 16'h0005, 3'b000, 16'h0013, 16'h0010, 1'b0, 1'b1, 16'h0023, 1'b1, 1'b0);
    look(16'h0003, 1'b0);
    issue(16'h0005, 16'h0005, 3'b000, 16'h0013, 16'h0010, 1'b0, 1'b1, 16'h0023, 1'b1, 1'b0);
    look(16'h0003, 1'b1);
    issue(16'h0005, 16'h0005, 3'b000, 16'h0013, 16'h0010, 1'b0, 1'b1, 16'h0023, 1'b1, 1'b0);
    idle(); idle();
    look(16'h0003, 1'b1);
    look(16'h00F3, 1'b1);
    issue(16'h0005, 16'h0006, 3'b000, 16'h0013, 16'h0010, 1'b0, 1'b0, 16'h0014, 1'b0, 1'b0);
    idle(); idle();
    look(16'h0003, 1'b1);
    issue(16'h0005, 16'h0006, 3'b000, 16'h0013, 16'h0010, 1'b0, 1'b0, 16'h0014, 1'b0, 1'b0);
    idle(); idle();
    look(16'h0003, 1'b0);

    // Flush squashes capture but not an update already in flight.
    drive(16'h0007, 16'h0007, 3'b000, 16'h0015, 16'h0002, 1'b0, 1'b1);
    idle(); idle();
    look(16'h0005, 1'b0);
    issue(16'h0007, 16'h0007, 3'b000, 16'h0016, 16'h0002, 1'b1, 1'b1, 16'h0018, 1'b0, 1'b0);
    drive(16'h0007, 16'h0007, 3'b000, 16'h0017, 16'h0002, 1'b0, 1'b1);
    idle(); idle();
    look(16'h0006, 1'b1);
    look(16'h0007, 1'b0);

    // Reset while a branch is valid: no update, table back to weak not-taken.
    issue(16'h0003, 16'h0003, 3'b000, 16'h0018, 16'h0002, 1'b1, 1'b1, 16'h001A, 1'b0, 1'b0);
    issue(16'h0003, 16'h0003, 3'b000, 16'h0018, 16'h0002, 1'b1, 1'b1, 16'h001A, 1'b0, 1'b0);
    @(posedge Clk); #1;
    InValid = 1'b0; Rst = 1'b1;
    look(16'h0008, 1'b1);
    @(posedge Clk); #1;
    Rst = 1'b0;
    look(16'h0008, 1'b0);
    look(16'h0006, 1'b0);

    // Reserved condition: never taken, flagged, counted, no table change.
    issue(16'h0004, 16'h0004, 3'b000, 16'h0019, 16'h0003, 1'b0, 1'b1, 16'h001C, 1'b1, 1'b0);
    idle(); idle();
    look(16'h0009, 1'b1);
    for (int i = 0; i < 4; i++)
      issue(16'h0004, 16'h0004, 3'b011, 16'h0019, 16'h0003, 1'b1, 1'b0, 16'h001A, 1'b1, 1'b1);
    idle(); idle();
    look(16'h0009, 1'b1);

    wait_cyc = 0;
    while (sb_q.size() != 0 && wait_cyc < 20) begin
      @(posedge Clk);
      wait_cyc++;
    end
    repeat (2) @(posedge Clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
